// File: rtl/axi_lite_mask_regs.sv
// axi_lite_mask_regs
// AXI4-Lite slave register bank for the mask datapath. Holds MASK_N,
// MASK_DATA, OUTPUT_ADDR and CTRL and drives them to the datapath. A CTRL
// write can fire a one-cycle start pulse. A sticky done flag is readable
// and write-1-to-clear. Each of the write and read paths allows one
// outstanding transaction, and the two paths are independent.
module axi_lite_mask_regs #(
  parameter int S_AXI_DATA_WIDTH = 32,
  parameter int S_AXI_ADDR_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  // write address channel
  input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  // write data channel
  input  logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  // write response channel
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  // read address channel
  input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  // read data channel
  output logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  // mask datapath side
  output logic [4:0]                    MASK_N_O,
  output logic [31:0]                   MASK_DATA_O,
  output logic [31:0]                   MASK_OADDR_O,
  output logic                          MASK_VALID_O,
  output logic                          MASK_START_O,
  input  logic                          MASK_DONE_I
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  // first byte address past the register map (STATUS is the last word)
  localparam logic [S_AXI_ADDR_WIDTH-1:0] ADDR_LIMIT = S_AXI_ADDR_WIDTH'(32'h0000_0014);

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,   // nothing latched
    W_WAIT = 2'b01,   // exactly one of AW / W latched
    W_RESP = 2'b10    // write committed, BVALID held until BREADY
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_e;

  // Per-byte merge of new write data over the old register value.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return res;
  endfunction

  // Address lies inside the register map; addr[1:0] play no part in the result.
  function automatic logic addr_ok(input logic [S_AXI_ADDR_WIDTH-1:0] a);
    return (a < ADDR_LIMIT);
  endfunction

  // Bus view of a register word. Unused bits read as zero.
  function automatic logic [31:0] reg_view(input logic [2:0]  idx,
                                           input logic [4:0]  n_v,
                                           input logic [31:0] data_v,
                                           input logic [31:0] oaddr_v,
                                           input logic        valid_v,
                                           input logic        done_v);
    logic [31:0] res;
    case (idx)
      3'd0:    res = {27'd0, n_v};
      3'd1:    res = data_v;
      3'd2:    res = oaddr_v;
      3'd3:    res = {31'd0, valid_v};
      3'd4:    res = {31'd0, done_v};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // ---------------- state ----------------
  w_state_e w_state_q, w_state_d;
  logic        aw_lat_q, aw_lat_d;
  logic [S_AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic        w_lat_q, w_lat_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;

  r_state_e r_state_q, r_state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic [4:0]  mask_n_q, mask_n_d;
  logic [31:0] mask_data_q, mask_data_d;
  logic [31:0] mask_oaddr_q, mask_oaddr_d;
  logic        mask_valid_q, mask_valid_d;
  logic        start_q, start_d;
  logic        done_q, done_d;

  // ---------------- combinational helpers ----------------
  logic        aw_hs_s, w_hs_s, ar_hs_s;
  logic        aw_have_s, w_have_s;
  logic [S_AXI_ADDR_WIDTH-1:0] wr_addr_s;
  logic [31:0] wr_data_s;
  logic [3:0]  wr_strb_s;
  logic        wr_addr_ok_s;
  logic [2:0]  wr_idx_s;
  logic [31:0] wr_cur_s;
  logic [31:0] wr_merged_s;
  logic        wr_commit_s;
  logic        done_clr_s;

  assign aw_hs_s = S_AXI_AWVALID & awready_q;
  assign w_hs_s  = S_AXI_WVALID & wready_q;
  assign ar_hs_s = S_AXI_ARVALID & arready_q;

  // A beat counts as present when it was latched earlier or is handshaking now,
  // which gives the single-cycle AW/W-to-BVALID path when both arrive together.
  assign aw_have_s    = aw_lat_q | aw_hs_s;
  assign w_have_s     = w_lat_q | w_hs_s;
  assign wr_addr_s    = aw_lat_q ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data_s    = w_lat_q ? w_data_q : S_AXI_WDATA;
  assign wr_strb_s    = w_lat_q ? w_strb_q : S_AXI_WSTRB;
  assign wr_addr_ok_s = addr_ok(wr_addr_s);
  assign wr_idx_s     = wr_addr_s[4:2];
  assign wr_cur_s     = reg_view(wr_idx_s, mask_n_q, mask_data_q, mask_oaddr_q,
                                 mask_valid_q, done_q);
  assign wr_merged_s  = strb_merge(wr_cur_s, wr_data_s, wr_strb_s);

  // Write-path next state: latch AW/W, commit once both are present, hold B until accepted.
  always_comb begin
    w_state_d   = w_state_q;
    aw_lat_d    = aw_lat_q;
    aw_addr_d   = aw_addr_q;
    w_lat_d     = w_lat_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    wr_commit_s = 1'b0;
    case (w_state_q)
      W_IDLE, W_WAIT: begin
        if (aw_hs_s) begin
          aw_lat_d  = 1'b1;
          aw_addr_d = S_AXI_AWADDR;
        end else begin
          aw_lat_d  = aw_lat_q;
          aw_addr_d = aw_addr_q;
        end
        if (w_hs_s) begin
          w_lat_d  = 1'b1;
          w_data_d = S_AXI_WDATA;
          w_strb_d = S_AXI_WSTRB;
        end else begin
          w_lat_d  = w_lat_q;
          w_data_d = w_data_q;
          w_strb_d = w_strb_q;
        end
        if (aw_have_s && w_have_s) begin
          wr_commit_s = 1'b1;
          bvalid_d    = 1'b1;
          bresp_d     = wr_addr_ok_s ? RESP_OKAY : RESP_SLVERR;
          w_state_d   = W_RESP;
        end else if (aw_have_s || w_have_s) begin
          w_state_d   = W_WAIT;
        end else begin
          w_state_d   = W_IDLE;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          aw_lat_d  = 1'b0;
          w_lat_d   = 1'b0;
          w_state_d = W_IDLE;
        end else begin
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
        end
      end
      default: begin
        bvalid_d  = 1'b0;
        aw_lat_d  = 1'b0;
        w_lat_d   = 1'b0;
        w_state_d = W_IDLE;
      end
    endcase
    // READY is registered and looks at the state being entered, so it is low
    // during reset and while a response is pending.
    awready_d = ~aw_lat_d & (w_state_d != W_RESP);
    wready_d  = ~w_lat_d & (w_state_d != W_RESP);
  end

  // Register-bank next state: byte-merged writes, start pulse, sticky done (set beats clear).
  always_comb begin
    mask_n_d     = mask_n_q;
    mask_data_d  = mask_data_q;
    mask_oaddr_d = mask_oaddr_q;
    mask_valid_d = mask_valid_q;
    start_d      = 1'b0;
    done_clr_s   = 1'b0;
    if (wr_commit_s && wr_addr_ok_s) begin
      case (wr_idx_s)
        3'd0: mask_n_d     = wr_merged_s[4:0];
        3'd1: mask_data_d  = wr_merged_s;
        3'd2: mask_oaddr_d = wr_merged_s;
        3'd3: begin
          if (wr_strb_s[0]) begin
            mask_valid_d = wr_data_s[0];
            start_d      = wr_data_s[1];
          end else begin
            mask_valid_d = mask_valid_q;
            start_d      = 1'b0;
          end
        end
        3'd4: begin
          if (wr_strb_s[0] && wr_data_s[0]) begin
            done_clr_s = 1'b1;
          end else begin
            done_clr_s = 1'b0;
          end
        end
        default: done_clr_s = 1'b0;
      endcase
    end else begin
      start_d    = 1'b0;
      done_clr_s = 1'b0;
    end
    if (MASK_DONE_I) begin
      done_d = 1'b1;
    end else if (done_clr_s) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end
  end

  // Read-path next state: capture a snapshot of the addressed register on AR, hold it until RREADY.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          rvalid_d  = 1'b1;
          r_state_d = R_RESP;
          if (addr_ok(S_AXI_ARADDR)) begin
            // current register contents, so a write landing on this edge is not yet visible
            rdata_d = reg_view(S_AXI_ARADDR[4:2], mask_n_q, mask_data_q, mask_oaddr_q,
                               mask_valid_q, done_q);
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = 32'd0;
            rresp_d = RESP_SLVERR;
          end
        end else begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          rvalid_d  = 1'b1;
          r_state_d = R_RESP;
        end
      end
      default: begin
        rvalid_d  = 1'b0;
        r_state_d = R_IDLE;
      end
    endcase
    arready_d = ~rvalid_d;
  end

  // Write-path registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      aw_lat_q  <= 1'b0;
      aw_addr_q <= '0;
      w_lat_q   <= 1'b0;
      w_data_q  <= 32'd0;
      w_strb_q  <= 4'd0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      aw_lat_q  <= aw_lat_d;
      aw_addr_q <= aw_addr_d;
      w_lat_q   <= w_lat_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Read-path registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Register bank, start pulse and done flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mask_n_q     <= 5'd0;
      mask_data_q  <= 32'd0;
      mask_oaddr_q <= 32'd0;
      mask_valid_q <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      mask_n_q     <= mask_n_d;
      mask_data_q  <= mask_data_d;
      mask_oaddr_q <= mask_oaddr_d;
      mask_valid_q <= mask_valid_d;
      start_q      <= start_d;
      done_q       <= done_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign MASK_N_O      = mask_n_q;
  assign MASK_DATA_O   = mask_data_q;
  assign MASK_OADDR_O  = mask_oaddr_q;
  assign MASK_VALID_O  = mask_valid_q;
  assign MASK_START_O  = start_q;

endmodule
